bus_host_arbiter: RTL and testbench

BUS_HOST_ARBITER -- requirements
Module: bus_host_arbiter

---
 rtl/bus_host_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_bus_host_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_host_arbiter.sv
// Round-robin N:1 bus host arbiter with in-order response routing through an ID FIFO.
// Optional performance counters are enabled with the BUS_ARB_PERF_CNT_EN macro.
module bus_host_arbiter #(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NrHosts-1:0]                     host_req_i,
    input  logic [NrHosts-1:0]                     host_we_i,
    input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
    output logic [NrHosts-1:0]                     host_gnt_o,
    output logic [NrHosts-1:0]                     host_rvalid_o,
    output logic [NrHosts-1:0]                     host_err_o,
    output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
    output logic                                   device_req_o,
    output logic                                   device_we_o,
    output logic [AddressWidth-1:0]                device_addr_o,
    output logic [DataWidth/8-1:0]                 device_be_o,
    output logic [DataWidth-1:0]                   device_wdata_o,
    input  logic                                   device_gnt_i,
    input  logic                                   device_rvalid_i,
    input  logic                                   device_err_i,
    input  logic [DataWidth-1:0]                   device_rdata_i,
    output logic                                   resp_unexpected_o,
    output logic [NrHosts-1:0][31:0]               perf_grant_cnt_o,
    output logic [31:0]                            perf_conflict_cnt_o
);

    localparam int unsigned IdxW = $clog2(NrHosts);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam idx_t LastHost  = idx_t'(NrHosts - 1);
    localparam ptr_t LastSlot  = ptr_t'(MaxOutstanding - 1);
    localparam cnt_t FullCount = cnt_t'(MaxOutstanding);

    typedef enum logic [0:0] {StArb, StHold} state_e;

    state_e      state_q, state_d;
    idx_t        held_q, held_d;
    idx_t        rr_q;
    idx_t        fifo_q [MaxOutstanding];
    ptr_t        wr_q, rd_q;
    cnt_t        count_q;

    idx_t        winner_arb;
    idx_t        winner;
    idx_t        head;
    logic        found;
    int unsigned rr_idx;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        pop;

    function automatic idx_t idx_inc(idx_t i);
        return (i == LastHost) ? '0 : i + idx_t'(1);
    endfunction

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == LastSlot) ? '0 : p + ptr_t'(1);
    endfunction

    // Round-robin search starting at rr_q, wrapping modulo NrHosts.
    always_comb begin
        winner_arb = rr_q;
        found      = 1'b0;
        rr_idx     = 0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            rr_idx = (32'(rr_q) + i) % NrHosts;
            if (!found && host_req_i[rr_idx]) begin
                winner_arb = idx_t'(rr_idx);
                found      = 1'b1;
            end
        end
    end

    // Fullness uses the registered count only, so a same-cycle pop never unblocks a request.
    assign fifo_full  = (count_q == FullCount);
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_q];
    assign winner     = (state_q == StHold) ? held_q : winner_arb;

    assign device_req_o   = ~rst_i & (|host_req_i) & ~fifo_full;
    assign device_we_o    = host_we_i[winner];
    assign device_addr_o  = host_addr_i[winner];
    assign device_be_o    = host_be_i[winner];
    assign device_wdata_o = host_wdata_i[winner];

    assign accept            = device_req_o & device_gnt_i;
    assign pop               = ~rst_i & device_rvalid_i & ~fifo_empty;
    assign resp_unexpected_o = ~rst_i & device_rvalid_i & fifo_empty;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        case (state_q)
            StArb: begin
                if (device_req_o && !device_gnt_i) begin
                    state_d = StHold;
                    held_d  = winner;
                end
            end
            StHold: begin
                if (device_gnt_i) begin
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        if (accept) begin
            host_gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = device_rdata_i;
        end
    end

    assign host_err_o = {NrHosts{device_err_i}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StArb;
            held_q  <= '0;
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int unsigned s = 0; s < MaxOutstanding; s++) begin
                fifo_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            if (accept) begin
                fifo_q[wr_q] <= winner;
                wr_q         <= ptr_inc(wr_q);
                rr_q         <= idx_inc(winner);
            end
            if (pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            if (accept && !pop) begin
                count_q <= count_q + cnt_t'(1);
            end else if (pop && !accept) begin
                count_q <= count_q - cnt_t'(1);
            end
        end
    end

`ifdef BUS_ARB_PERF_CNT_EN
    logic [NrHosts-1:0][31:0] grant_cnt_q;
    logic [31:0]              conflict_cnt_q;
    int unsigned              req_count;
    logic                     conflict;

    always_comb begin
        req_count = 0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            req_count = req_count + 32'(host_req_i[h]);
        end
        conflict = (req_count >= 2);
    end

    // Both counters saturate at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            for (int unsigned h = 0; h < NrHosts; h++) begin
                if (accept && (winner == idx_t'(h)) && (grant_cnt_q[h] != '1)) begin
                    grant_cnt_q[h] <= grant_cnt_q[h] + 32'd1;
                end
            end
            if (conflict && (conflict_cnt_q != '1)) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign perf_grant_cnt_o    = grant_cnt_q;
    assign perf_conflict_cnt_o = conflict_cnt_q;
`else
    assign perf_grant_cnt_o    = '0;
    assign perf_conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_bus_host_arbiter;

    localparam int unsigned NrHosts        = 2;
    localparam int unsigned MaxOutstanding = 2;
    localparam int unsigned DataWidth      = 32;
    localparam int unsigned AddressWidth   = 32;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic [NrHosts-1:0]                   host_req;
    logic [NrHosts-1:0]                   host_we;
    logic [NrHosts-1:0][AddressWidth-1:0] host_addr;
    logic [NrHosts-1:0][DataWidth-1:0]    host_wdata;
    logic [NrHosts-1:0][DataWidth/8-1:0]  host_be;
    logic [NrHosts-1:0]                   host_gnt;
    logic [NrHosts-1:0]                   host_rvalid;
    logic [NrHosts-1:0]                   host_err;
    logic [NrHosts-1:0][DataWidth-1:0]    host_rdata;
    logic                                 device_req;
    logic                                 device_we;
    logic [AddressWidth-1:0]              device_addr;
    logic [DataWidth/8-1:0]               device_be;
    logic [DataWidth-1:0]                 device_wdata;
    logic                                 device_gnt;
    logic                                 device_rvalid;
    logic                                 device_err;
    logic [DataWidth-1:0]                 device_rdata;
    logic                                 resp_unexpected;
    logic [NrHosts-1:0][31:0]             perf_grant_cnt;
    logic [31:0]                          perf_conflict_cnt;

    bus_host_arbiter #(
        .NrHosts        (NrHosts),
        .MaxOutstanding (MaxOutstanding),
        .DataWidth      (DataWidth),
        .AddressWidth   (AddressWidth)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .host_req_i          (host_req),
        .host_we_i           (host_we),
        .host_addr_i         (host_addr),
        .host_wdata_i        (host_wdata),
        .host_be_i           (host_be),
        .host_gnt_o          (host_gnt),
        .host_rvalid_o       (host_rvalid),
        .host_err_o          (host_err),
        .host_rdata_o        (host_rdata),
        .device_req_o        (device_req),
        .device_we_o         (device_we),
        .device_addr_o       (device_addr),
        .device_be_o         (device_be),
        .device_wdata_o      (device_wdata),
        .device_gnt_i        (device_gnt),
        .device_rvalid_i     (device_rvalid),
        .device_err_i        (device_err),
        .device_rdata_i      (device_rdata),
        .resp_unexpected_o   (resp_unexpected),
        .perf_grant_cnt_o    (perf_grant_cnt),
        .perf_conflict_cnt_o (perf_conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_in(input logic [1:0] req, input logic gnt, input logic rv,
                          input logic [31:0] rd);
        host_req      = req;
        device_gnt    = gnt;
        device_rvalid = rv;
        device_rdata  = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fixed_payload();
        host_addr[0]  = 32'h0000_1000;
        host_addr[1]  = 32'h0000_2000;
        host_wdata[0] = 32'hBEEF_0000;
        host_wdata[1] = 32'hCAFE_0001;
        host_be[0]    = 4'hF;
        host_be[1]    = 4'h3;
        host_we       = 2'b10;
        device_err    = 1'b0;
    endtask

    // Holds reset for two edges, checking outputs stay quiet even with activity on the inputs.
    task automatic do_reset();
        rst = 1'b1;
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        next_cycle();
        set_in(2'b11, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        check("rst_device_req", 64'(device_req), 64'd0);
        check("rst_host_gnt", 64'(host_gnt), 64'd0);
        check("rst_host_rvalid", 64'(host_rvalid), 64'd0);
        check("rst_unexpected", 64'(resp_unexpected), 64'd0);
        check("rst_perf_grant", 64'(perf_grant_cnt), 64'd0);
        check("rst_perf_conflict", 64'(perf_conflict_cnt), 64'd0);
        next_cycle();
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        exp_dreq;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rv;
        logic        exp_unexp;
    } vec_t;

    vec_t vecs[11];

    // Reference model state: outstanding host IDs in order, round-robin pointer, held winner.
    int m_q[$];
    int m_rr;
    int m_held;

    function automatic int first_req(input logic [1:0] req, input int rr);
        for (int k = 0; k < NrHosts; k++) begin
            if (req[(rr + k) % NrHosts]) return (rr + k) % NrHosts;
        end
        return rr;
    endfunction

    initial begin
        fixed_payload();

        // Alternating grants, FIFO-full blocking, in-order response routing, stray responses.
        vecs[0]  = '{2'b00, 1'b0, 1'b1, 32'h1111_0000, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[1]  = '{2'b11, 1'b1, 1'b0, 32'h1111_0001, 1'b1, 2'b01, 2'b00, 1'b0};
        vecs[2]  = '{2'b11, 1'b1, 1'b1, 32'h1111_0002, 1'b1, 2'b10, 2'b01, 1'b0};
        vecs[3]  = '{2'b11, 1'b1, 1'b0, 32'h1111_0003, 1'b1, 2'b01, 2'b00, 1'b0};
        vecs[4]  = '{2'b11, 1'b1, 1'b0, 32'h1111_0004, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[5]  = '{2'b11, 1'b1, 1'b1, 32'h1111_0005, 1'b0, 2'b00, 2'b10, 1'b0};
        vecs[6]  = '{2'b11, 1'b1, 1'b0, 32'h1111_0006, 1'b1, 2'b10, 2'b00, 1'b0};
        vecs[7]  = '{2'b00, 1'b0, 1'b1, 32'h1111_0007, 1'b0, 2'b00, 2'b01, 1'b0};
        vecs[8]  = '{2'b00, 1'b0, 1'b1, 32'h1111_0008, 1'b0, 2'b00, 2'b10, 1'b0};
        vecs[9]  = '{2'b00, 1'b0, 1'b1, 32'h1111_0009, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[10] = '{2'b00, 1'b0, 1'b0, 32'h1111_000A, 1'b0, 2'b00, 2'b00, 1'b0};

        do_reset();
        for (int v = 0; v < 11; v++) begin
            set_in(vecs[v].req, vecs[v].gnt, vecs[v].rv, vecs[v].rd);
            @(negedge clk);
            check($sformatf("vec%0d_device_req", v), 64'(device_req), 64'(vecs[v].exp_dreq));
            check($sformatf("vec%0d_host_gnt", v), 64'(host_gnt), 64'(vecs[v].exp_gnt));
            check($sformatf("vec%0d_host_rvalid", v), 64'(host_rvalid), 64'(vecs[v].exp_rv));
            check($sformatf("vec%0d_unexpected", v), 64'(resp_unexpected),
                  64'(vecs[v].exp_unexp));
            if (vecs[v].rv) begin
                check($sformatf("vec%0d_rdata", v), 64'(host_rdata), {vecs[v].rd, vecs[v].rd});
            end
            next_cycle();
        end

        // Held winner keeps its payload while stalled, then response data routes by ID.
        do_reset();
        set_in(2'b10, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("hold_c1_req", 64'(device_req), 64'd1);
        check("hold_c1_addr", 64'(device_addr), 64'h2000);
        next_cycle();
        for (int c = 2; c <= 3; c++) begin
            set_in(2'b11, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check($sformatf("hold_c%0d_addr", c), 64'(device_addr), 64'h2000);
            check($sformatf("hold_c%0d_gnt", c), 64'(host_gnt), 64'd0);
            next_cycle();
        end
        set_in(2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("hold_c4_gnt", 64'(host_gnt), 64'b10);
        check("hold_c4_addr", 64'(device_addr), 64'h2000);
        check("hold_c4_wdata", 64'(device_wdata), 64'hCAFE_0001);
        check("hold_c4_be", 64'(device_be), 64'h3);
        check("hold_c4_we", 64'(device_we), 64'd1);
        next_cycle();
        set_in(2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("hold_c5_gnt", 64'(host_gnt), 64'b01);
        check("hold_c5_addr", 64'(device_addr), 64'h1000);
        next_cycle();
        set_in(2'b00, 1'b0, 1'b1, 32'hA5A5_A5A5);
        @(negedge clk);
        check("route_first_rvalid", 64'(host_rvalid), 64'b10);
        check("route_first_rdata", 64'(host_rdata[1]), 64'hA5A5_A5A5);
        next_cycle();
        set_in(2'b00, 1'b0, 1'b1, 32'h5A5A_5A5A);
        @(negedge clk);
        check("route_second_rvalid", 64'(host_rvalid), 64'b01);
        check("route_second_rdata", 64'(host_rdata[0]), 64'h5A5A_5A5A);
        next_cycle();

        // Ten conflicting cycles with alternating grants, then a reset mid-run.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(2'b11, 1'b1, (i > 0), 32'h0);
            @(negedge clk);
            check($sformatf("perf_gnt%0d", i), 64'(host_gnt), (i % 2 == 0) ? 64'b01 : 64'b10);
            next_cycle();
        end
        set_in(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
`ifdef BUS_ARB_PERF_CNT_EN
        check("perf_grant_cnt", 64'(perf_grant_cnt), {32'd5, 32'd5});
        check("perf_conflict_cnt", 64'(perf_conflict_cnt), 64'd10);
`else
        check("perf_grant_cnt", 64'(perf_grant_cnt), 64'd0);
        check("perf_conflict_cnt", 64'(perf_conflict_cnt), 64'd0);
`endif
        next_cycle();
        rst = 1'b1;
        set_in(2'b11, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        check("midrst_perf_grant", 64'(perf_grant_cnt), 64'd0);
        check("midrst_perf_conflict", 64'(perf_conflict_cnt), 64'd0);
        check("midrst_device_req", 64'(device_req), 64'd0);
        check("midrst_rvalid", 64'(host_rvalid), 64'd0);
        check("midrst_unexpected", 64'(resp_unexpected), 64'd0);
        next_cycle();
        rst = 1'b0;
        set_in(2'b00, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        check("postrst_unexpected", 64'(resp_unexpected), 64'd1);
        check("postrst_rvalid", 64'(host_rvalid), 64'd0);
        next_cycle();

        // Randomized traffic against the reference model.
        do_reset();
        m_q.delete();
        m_rr   = 0;
        m_held = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [1:0] req;
            logic       gnt;
            logic       rv;
            logic       exp_dreq;
            logic [1:0] exp_gnt;
            logic [1:0] exp_rv;
            logic       exp_unexp;
            int         w;

            req = 2'($urandom_range(0, 3));
            gnt = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 2) == 0);
            for (int h = 0; h < NrHosts; h++) begin
                host_addr[h]  = $urandom;
                host_wdata[h] = $urandom;
                host_be[h]    = 4'($urandom);
            end
            host_we    = 2'($urandom);
            device_err = 1'($urandom);
            set_in(req, gnt, rv, $urandom);

            w         = (m_held >= 0) ? m_held : first_req(req, m_rr);
            exp_dreq  = (req != 0) && (m_q.size() < MaxOutstanding);
            exp_gnt   = (exp_dreq && gnt) ? 2'(1 << w) : 2'b00;
            exp_rv    = (rv && m_q.size() > 0) ? 2'(1 << m_q[0]) : 2'b00;
            exp_unexp = rv && (m_q.size() == 0);

            @(negedge clk);
            check("rand_device_req", 64'(device_req), 64'(exp_dreq));
            check("rand_host_gnt", 64'(host_gnt), 64'(exp_gnt));
            check("rand_host_rvalid", 64'(host_rvalid), 64'(exp_rv));
            check("rand_unexpected", 64'(resp_unexpected), 64'(exp_unexp));
            check("rand_host_err", 64'(host_err), 64'({device_err, device_err}));
            if (exp_dreq) begin
                check("rand_device_addr", 64'(device_addr), 64'(host_addr[w]));
                check("rand_device_wdata", 64'(device_wdata), 64'(host_wdata[w]));
            end

            if (rv && m_q.size() > 0) void'(m_q.pop_front());
            if (exp_dreq && gnt) begin
                m_q.push_back(w);
                m_rr = (w + 1) % NrHosts;
            end
            if (m_held < 0) begin
                if (exp_dreq && !gnt) m_held = w;
            end else if (gnt) begin
                m_held = -1;
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
